winograd_pe: RTL and testbench
==============================

Name: winograd_pe

Overview:
- One processing element of the Winograd-domain systolic array.
- Takes a 6x6 transformed input tile (U, 14-bit) and a 6x6 transformed weight tile (V, 12-bit), and registers their elementwise product (12-bit, scaled, saturated) with per-element output coordinates and output-depth tag.
- Forwards the incoming data and weight streams, registered, to neighbouring PEs: data flows one way, weights the other.

Parameters:
- None. All widths are fixed: data 14, weight 12, result 12, index 9, od 8.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- data_tile_i  in  6x6x14 signed  transformed data tile
- data_valid_i  in  1  data tile valid
- data_x_index_i  in  9  tile origin row index
- data_y_index_i  in  9  tile origin column index
- weight_tile_i  in  6x6x12 signed  transformed weight tile
- weight_valid_i  in  1  weight tile valid
- weight_size_type_i  in  1  1 = 3x3 filter, 0 = other; carried only, no arithmetic effect
- weight_od_i  in  8  output-depth (channel) tag
- result_tile_o  out  6x6x12 signed  elementwise product tile
- result_od_o  out  8  output-depth tag of result
- result_i_o  out  6x6x9  row coordinate per element
- result_j_o  out  6x6x9  column coordinate per element
- result_valid_o  out  1  result valid
- data_tile_reg_o  out  6x6x14 signed  forwarded data tile
- data_valid_o  out  1  forwarded data valid
- data_x_index_o  out  9  forwarded x index
- data_y_index_o  out  9  forwarded y index
- weight_tile_reg_o  out  6x6x12 signed  forwarded weight tile
- weight_valid_o  out  1  forwarded weight valid
- weight_size_type_o  out  1  forwarded size type
- weight_od_o  out  8  forwarded od

Behaviour:
- Reset: reset low clears every output register to 0 immediately, without waiting for a clock edge. This covers all tiles, indices, tags and valids. Outputs stay 0 while reset is low. Reset asserted mid-operation discards the in-flight result.
- Forwarding, latency 1 cycle:
  - Every rising edge registers data_tile_i, data_valid_i, data_x_index_i and data_y_index_i into the *_o forwarding outputs unconditionally, including invalid cycles.
  - The weight-side inputs are forwarded the same way.
- Compute fire condition: fire = data_valid_i AND weight_valid_i. There is no backpressure.
- Compute, latency 1 cycle: on an edge where fire=1, for every r,c in 0..5:
  - P = data_tile_i[r][c] * weight_tile_i[r][c], full 26-bit signed product.
  - S = P >>> 12, arithmetic shift (floor).
  - result_tile_o[r][c] = S saturated to [-2048, 2047].
  - result_i_o[r][c] = (data_x_index_i + r) mod 512.
  - result_j_o[r][c] = (data_y_index_i + c) mod 512. Indices are unsigned and wrap.
  - result_od_o = weight_od_i.
- result_valid_o is registered from fire on every edge.
- When fire=0: result_valid_o goes 0 next cycle; result_tile_o, indices and od hold their last values.
- Only one valid high: no result; the forwarding path is unaffected.
- Back-to-back fire cycles produce one result per cycle, throughput 1 tile per clock.
- All 36 lanes are computed in parallel with identical rules.

Test Plan:
- Reset low for 20 ns with nonzero inputs -> every output is 0. Release reset; next edge the forwarding outputs equal the inputs.
- Scaling and indices: data all 4096, weight all 8, x=10, y=15, od=3, both valids high for 1 cycle -> next cycle result_valid_o=1, every result_tile_o=8, result_i_o[r][c]=10+r, result_j_o[r][c]=15+c, result_od_o=3. Following cycle result_valid_o=0 and the values hold.
- Saturation and floor:
  - data -8192 * weight -2048 -> 2047.
  - data 8191 * weight -2048 -> -2048.
  - data -1 * weight 1 -> -1.
  - data 2 * weight 3 -> 0.
- Index wrap: x=510, y=511 -> result_i_o[3][*]=1, result_j_o[*][2]=1.
- Valid mismatch: data_valid_i=1, weight_valid_i=0 -> result_valid_o stays 0, result tile unchanged; data_valid_o=1 and weight_valid_o=0 one cycle later.
- Streaming: 4 consecutive fire cycles with distinct od tags 1..4 -> result_od_o shows 1,2,3,4 on consecutive cycles with result_valid_o held high.

Source files
------------

// File: rtl/winograd_pe.sv
`default_nettype none
// ============================================================================
// Module      : winograd_pe
// Description : Winograd-domain systolic processing element. Multiplies a
//               6x6 transformed data tile by a 6x6 transformed weight tile
//               elementwise, scales each product down by 2^12 (floor),
//               saturates it to 12 bits and tags each element with its output
//               coordinates and output-depth tag. The data and weight streams
//               are re-registered for the neighbouring PEs.
// Revision    : 1.0 - initial release
// ============================================================================
module winograd_pe (
  input  logic                     clk,
  input  logic                     reset,               // async, active low
  // data stream in
  input  logic [5:0][5:0][13:0]    data_tile_i,
  input  logic                     data_valid_i,
  input  logic [8:0]               data_x_index_i,
  input  logic [8:0]               data_y_index_i,
  // weight stream in
  input  logic [5:0][5:0][11:0]    weight_tile_i,
  input  logic                     weight_valid_i,
  input  logic                     weight_size_type_i,
  input  logic [7:0]               weight_od_i,
  // result
  output logic [5:0][5:0][11:0]    result_tile_o,
  output logic [7:0]               result_od_o,
  output logic [5:0][5:0][8:0]     result_i_o,
  output logic [5:0][5:0][8:0]     result_j_o,
  output logic                     result_valid_o,
  // data stream out
  output logic [5:0][5:0][13:0]    data_tile_reg_o,
  output logic                     data_valid_o,
  output logic [8:0]               data_x_index_o,
  output logic [8:0]               data_y_index_o,
  // weight stream out
  output logic [5:0][5:0][11:0]    weight_tile_reg_o,
  output logic                     weight_valid_o,
  output logic                     weight_size_type_o,
  output logic [7:0]               weight_od_o
);

  // Tile geometry and fixed-point scaling.
  localparam int              TILE       = 6;
  localparam int              FRAC_BITS  = 12;
  localparam logic [11:0]     RES_MAX    = 12'h7FF;   //  2047
  localparam logic [11:0]     RES_MIN    = 12'h800;   // -2048
  localparam logic signed [25:0] SAT_HI  = 26'sd2047;
  localparam logic signed [25:0] SAT_LO  = -26'sd2048;

  // --------------------------------------------------------------------------
  // One lane of the datapath: full 26-bit signed product, arithmetic shift
  // (floor towards -inf), then clamp into the signed 12-bit result range.
  // --------------------------------------------------------------------------
  function automatic logic [11:0] scale_sat(input logic [13:0] d,
                                            input logic [11:0] w);
    logic signed [25:0] prod;
    logic signed [25:0] shifted;
    prod    = $signed(d) * $signed(w);
    shifted = prod >>> FRAC_BITS;
    if (shifted > SAT_HI) begin
      scale_sat = RES_MAX;
    end else if (shifted < SAT_LO) begin
      scale_sat = RES_MIN;
    end else begin
      scale_sat = shifted[11:0];
    end
  endfunction

  // Forwarding registers (unconditional pipeline stage).
  logic [5:0][5:0][13:0] data_tile_q;
  logic                  data_valid_q;
  logic [8:0]            data_x_index_q;
  logic [8:0]            data_y_index_q;
  logic [5:0][5:0][11:0] weight_tile_q;
  logic                  weight_valid_q;
  logic                  weight_size_type_q;
  logic [7:0]            weight_od_q;

  // Result registers with their next-state values.
  logic [5:0][5:0][11:0] result_tile_q, result_tile_d;
  logic [5:0][5:0][8:0]  result_i_q,    result_i_d;
  logic [5:0][5:0][8:0]  result_j_q,    result_j_d;
  logic [7:0]            result_od_q,   result_od_d;
  logic                  result_valid_q, result_valid_d;

  // Combinational lane results, computed every cycle.
  logic [5:0][5:0][11:0] lane_tile;
  logic [5:0][5:0][8:0]  lane_i;
  logic [5:0][5:0][8:0]  lane_j;

  // A result is produced only when both streams present a valid tile.
  logic fire;
  assign fire = data_valid_i & weight_valid_i;

  // Evaluate all 36 lanes in parallel; indices wrap naturally at 9 bits.
  always_comb begin
    lane_tile = '0;
    lane_i    = '0;
    lane_j    = '0;
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++) begin
        lane_tile[r][c] = scale_sat(data_tile_i[r][c], weight_tile_i[r][c]);
        lane_i[r][c]    = data_x_index_i + 9'(r);
        lane_j[r][c]    = data_y_index_i + 9'(c);
      end
    end
  end

  // Capture lane results on fire; otherwise hold the previous result.
  always_comb begin
    result_tile_d  = result_tile_q;
    result_i_d     = result_i_q;
    result_j_d     = result_j_q;
    result_od_d    = result_od_q;
    result_valid_d = fire;
    if (fire) begin
      result_tile_d = lane_tile;
      result_i_d    = lane_i;
      result_j_d    = lane_j;
      result_od_d   = weight_od_i;
    end
  end

  // Forward both streams one cycle downstream, valid or not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_tile_q        <= '0;
      data_valid_q       <= 1'b0;
      data_x_index_q     <= '0;
      data_y_index_q     <= '0;
      weight_tile_q      <= '0;
      weight_valid_q     <= 1'b0;
      weight_size_type_q <= 1'b0;
      weight_od_q        <= '0;
    end else begin
      data_tile_q        <= data_tile_i;
      data_valid_q       <= data_valid_i;
      data_x_index_q     <= data_x_index_i;
      data_y_index_q     <= data_y_index_i;
      weight_tile_q      <= weight_tile_i;
      weight_valid_q     <= weight_valid_i;
      weight_size_type_q <= weight_size_type_i;
      weight_od_q        <= weight_od_i;
    end
  end

  // Result state register; reset discards any in-flight result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_tile_q  <= '0;
      result_i_q     <= '0;
      result_j_q     <= '0;
      result_od_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_tile_q  <= result_tile_d;
      result_i_q     <= result_i_d;
      result_j_q     <= result_j_d;
      result_od_q    <= result_od_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result_tile_o      = result_tile_q;
  assign result_od_o        = result_od_q;
  assign result_i_o         = result_i_q;
  assign result_j_o         = result_j_q;
  assign result_valid_o     = result_valid_q;

  assign data_tile_reg_o    = data_tile_q;
  assign data_valid_o       = data_valid_q;
  assign data_x_index_o     = data_x_index_q;
  assign data_y_index_o     = data_y_index_q;

  assign weight_tile_reg_o  = weight_tile_q;
  assign weight_valid_o     = weight_valid_q;
  assign weight_size_type_o = weight_size_type_q;
  assign weight_od_o        = weight_od_q;

endmodule
`default_nettype wire

// File: tb/tb_winograd_pe.sv
`default_nettype none
// ============================================================================
// Module      : tb_winograd_pe
// Description : Self-checking bench for winograd_pe. Directed corner cases
//               followed by random traffic, compared against an arithmetic
//               reference model of the PE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_winograd_pe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [5:0][5:0][13:0] data_tile_i;
  logic                  data_valid_i;
  logic [8:0]            data_x_index_i, data_y_index_i;
  logic [5:0][5:0][11:0] weight_tile_i;
  logic                  weight_valid_i, weight_size_type_i;
  logic [7:0]            weight_od_i;

  logic [5:0][5:0][11:0] result_tile_o;
  logic [7:0]            result_od_o;
  logic [5:0][5:0][8:0]  result_i_o, result_j_o;
  logic                  result_valid_o;
  logic [5:0][5:0][13:0] data_tile_reg_o;
  logic                  data_valid_o;
  logic [8:0]            data_x_index_o, data_y_index_o;
  logic [5:0][5:0][11:0] weight_tile_reg_o;
  logic                  weight_valid_o, weight_size_type_o;
  logic [7:0]            weight_od_o;

  winograd_pe dut (
    .clk                (clk),
    .reset              (reset),
    .data_tile_i        (data_tile_i),
    .data_valid_i       (data_valid_i),
    .data_x_index_i     (data_x_index_i),
    .data_y_index_i     (data_y_index_i),
    .weight_tile_i      (weight_tile_i),
    .weight_valid_i     (weight_valid_i),
    .weight_size_type_i (weight_size_type_i),
    .weight_od_i        (weight_od_i),
    .result_tile_o      (result_tile_o),
    .result_od_o        (result_od_o),
    .result_i_o         (result_i_o),
    .result_j_o         (result_j_o),
    .result_valid_o     (result_valid_o),
    .data_tile_reg_o    (data_tile_reg_o),
    .data_valid_o       (data_valid_o),
    .data_x_index_o     (data_x_index_o),
    .data_y_index_o     (data_y_index_o),
    .weight_tile_reg_o  (weight_tile_reg_o),
    .weight_valid_o     (weight_valid_o),
    .weight_size_type_o (weight_size_type_o),
    .weight_od_o        (weight_od_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what each output should show after the next edge.
  logic [5:0][5:0][13:0] m_dtile;
  logic                  m_dvalid;
  logic [8:0]            m_dx, m_dy;
  logic [5:0][5:0][11:0] m_wtile;
  logic                  m_wvalid, m_wst;
  logic [7:0]            m_wod;
  logic [5:0][5:0][11:0] m_res;
  logic [5:0][5:0][8:0]  m_ri, m_rj;
  logic [7:0]            m_rod;
  logic                  m_rv;

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Floor-divide the product by 4096 and clamp to signed 12 bits.
  function automatic logic [11:0] ref_lane(input int d, input int w);
    int p, q;
    p = d * w;
    q = p / 4096;
    if (p < 0 && (p % 4096) != 0) q = q - 1;
    if (q > 2047)  q = 2047;
    if (q < -2048) q = -2048;
    return 12'(q);
  endfunction

  task automatic model_clear();
    m_dtile = '0; m_dvalid = 0; m_dx = '0; m_dy = '0;
    m_wtile = '0; m_wvalid = 0; m_wst = 0; m_wod = '0;
    m_res = '0; m_ri = '0; m_rj = '0; m_rod = '0; m_rv = 0;
  endtask

  task automatic model_edge();
    int d, w;
    m_dtile = data_tile_i;   m_dvalid = data_valid_i;
    m_dx = data_x_index_i;   m_dy = data_y_index_i;
    m_wtile = weight_tile_i; m_wvalid = weight_valid_i;
    m_wst = weight_size_type_i; m_wod = weight_od_i;
    m_rv = data_valid_i && weight_valid_i;
    if (m_rv) begin
      m_rod = weight_od_i;
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < 6; c++) begin
          d = $signed(data_tile_i[r][c]);
          w = $signed(weight_tile_i[r][c]);
          m_res[r][c] = ref_lane(d, w);
          m_ri[r][c]  = 9'((int'(data_x_index_i) + r) % 512);
          m_rj[r][c]  = 9'((int'(data_y_index_i) + c) % 512);
        end
      end
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".res_tile"},  512'(result_tile_o),     512'(m_res));
    check({ph, ".res_i"},     512'(result_i_o),        512'(m_ri));
    check({ph, ".res_j"},     512'(result_j_o),        512'(m_rj));
    check({ph, ".res_od"},    512'(result_od_o),       512'(m_rod));
    check({ph, ".res_valid"}, 512'(result_valid_o),    512'(m_rv));
    check({ph, ".fwd_dtile"}, 512'(data_tile_reg_o),   512'(m_dtile));
    check({ph, ".fwd_dmisc"}, 512'({data_valid_o, data_x_index_o, data_y_index_o}),
                              512'({m_dvalid, m_dx, m_dy}));
    check({ph, ".fwd_wtile"}, 512'(weight_tile_reg_o), 512'(m_wtile));
    check({ph, ".fwd_wmisc"}, 512'({weight_valid_o, weight_size_type_o, weight_od_o}),
                              512'({m_wvalid, m_wst, m_wod}));
  endtask

  // One clock: advance the model with the current inputs, then sample.
  task automatic cycle(input string ph);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  task automatic fill(input logic [13:0] d, input logic [11:0] w);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        data_tile_i[r][c]   = d;
        weight_tile_i[r][c] = w;
      end
  endtask

  task automatic set_ctl(input logic dv, input logic wv, input logic [8:0] x,
                         input logic [8:0] y, input logic [7:0] od);
    data_valid_i = dv; weight_valid_i = wv;
    data_x_index_i = x; data_y_index_i = y; weight_od_i = od;
  endtask

  function automatic logic [13:0] rnd_d();
    case ($urandom_range(0, 7))
      0:       return 14'h2000;   // -8192
      1:       return 14'h1FFF;   //  8191
      default: return 14'($urandom);
    endcase
  endfunction

  function automatic logic [11:0] rnd_w();
    case ($urandom_range(0, 7))
      0:       return 12'h800;    // -2048
      1:       return 12'h7FF;    //  2047
      default: return 12'($urandom);
    endcase
  endfunction

  logic [13:0] sat_d [4] = '{14'h2000, 14'h1FFF, 14'h3FFF, 14'd2};
  logic [11:0] sat_w [4] = '{12'h800,  12'h800,  12'd1,    12'd3};
  logic [11:0] sat_e [4] = '{12'h7FF,  12'h800,  12'hFFF,  12'd0};

  initial begin
    // Reset with nonzero inputs: every output must read zero.
    reset = 1'b0;
    fill(14'h0123, 12'h045);
    weight_size_type_i = 1'b1;
    set_ctl(1, 1, 9'd7, 9'd9, 8'd5);
    model_clear();
    #20;
    compare_all("reset");

    @(negedge clk);
    reset = 1'b1;
    cycle("fwd_after_reset");

    // Scaling and coordinates.
    fill(14'd4096, 12'd8);
    weight_size_type_i = 1'b0;
    set_ctl(1, 1, 9'd10, 9'd15, 8'd3);
    cycle("scale");
    check("scale.valid", 512'(result_valid_o), 512'(1));
    check("scale.lane55", 512'(result_tile_o[5][5]), 512'(8));
    check("scale.i_2_4", 512'(result_i_o[2][4]), 512'(12));
    check("scale.j_2_4", 512'(result_j_o[2][4]), 512'(19));
    check("scale.od", 512'(result_od_o), 512'(3));
    set_ctl(0, 0, 9'd0, 9'd0, 8'd0);
    cycle("scale_hold");
    check("hold.valid", 512'(result_valid_o), 512'(0));
    check("hold.lane00", 512'(result_tile_o[0][0]), 512'(8));

    // Saturation and floor corners.
    for (int k = 0; k < 4; k++) begin
      fill(sat_d[k], sat_w[k]);
      set_ctl(1, 1, 9'd0, 9'd0, 8'(k));
      cycle("sat");
      check("sat.lane34", 512'(result_tile_o[3][4]), 512'(sat_e[k]));
    end

    // Index wrap at 512.
    fill(14'd100, 12'd100);
    set_ctl(1, 1, 9'd510, 9'd511, 8'd9);
    cycle("wrap");
    check("wrap.i_3_0", 512'(result_i_o[3][0]), 512'(1));
    check("wrap.j_0_2", 512'(result_j_o[0][2]), 512'(1));

    // Only data valid: no result, forwarding still flows.
    fill(14'd999, 12'd77);
    set_ctl(1, 0, 9'd1, 9'd2, 8'd44);
    cycle("mismatch");
    check("mismatch.rvalid", 512'(result_valid_o), 512'(0));
    check("mismatch.dvalid", 512'(data_valid_o), 512'(1));
    check("mismatch.wvalid", 512'(weight_valid_o), 512'(0));

    // Back-to-back fire stream with od 1..4.
    for (int k = 1; k <= 4; k++) begin
      fill(rnd_d(), rnd_w());
      set_ctl(1, 1, 9'($urandom), 9'($urandom), 8'(k));
      cycle("stream");
      check("stream.od", 512'(result_od_o), 512'(k));
      check("stream.valid", 512'(result_valid_o), 512'(1));
    end

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) begin
          data_tile_i[r][c]   = rnd_d();
          weight_tile_i[r][c] = rnd_w();
        end
      weight_size_type_i = 1'($urandom);
      set_ctl(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              9'($urandom), 9'($urandom), 8'($urandom));
      cycle("random");
    end

    // Reset mid-stream: outputs clear at once and stay clear.
    fill(14'd4096, 12'd8);
    set_ctl(1, 1, 9'd20, 9'd30, 8'd66);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    compare_all("midreset");
    @(posedge clk);
    #1;
    compare_all("midreset_held");
    @(negedge clk);
    reset = 1'b1;
    cycle("after_midreset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
